spart_gen2: RTL and testbench
=============================

# spart_gen2

Second-generation SPART: memory-mapped byte UART with depth-parametrised TX/RX queues, a programmable 13-bit baud divisor, sticky error reporting and optional parity. It sits on the processor's 4-register I/O bus, keeping the DBUF/SREG/DBL/DBH map, and drives the board TX/RX pins.

## Interface
- DEPTH, 8: entries per queue; power of two, 2..64.
- DEFAULT_DIV, 13'd434: reset baud divisor in clk cycles per bit (50 MHz / 115200).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- iocs_n  in  1  active-low chip select.
- iorw_n  in  1  1 = read, 0 = write.
- ioaddr  in  2  00 DBUF, 01 SREG, 10 DBL, 11 DBH.
- databus  inout  8  driven by block only when iocs_n=0 and iorw_n=1, else Z.
- tx_q_full  out  1  TX queue holds DEPTH entries.
- rx_q_empty  out  1  RX queue holds 0 entries.
- rx_err  out  1  mirror of sticky error bit DBH[5].
- TX  out  1  serial out, idle high.
- RX  in  1  serial in, asynchronous.

## Operation
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Write (iocs_n=0, iorw_n=0) takes effect at posedge. Read data is combinational from ioaddr.
- DBUF write: push to TX queue; dropped silently when full.
- DBUF read: drive RX head and pop at the posedge. When empty, drive 8'h00 with no pop.
- SREG (read-only): [7:4] = min(TX free slots, 15), [3:0] = min(RX occupancy, 15).
- DBL: divisor[7:0]. DBH: [4:0] = divisor[12:8], [5] = sticky error, [7:6] = parity control.
  - Sticky error: write 1 clears it, write 0 leaves it.
- Effective divisor = max(divisor, 16). It is latched at each frame start; a change mid-frame applies to the next frame.
- TX FSM IDLE→START→DATA(8, LSB first)→[PARITY]→STOP→IDLE.
  - Each state lasts one divisor period.
  - IDLE pops the queue head when the queue is non-empty.
- RX path:
  - 2-flop synchroniser.
  - FSM IDLE→START→DATA→[PARITY]→STOP.
  - IDLE→START on a synchronised falling edge.
  - START samples at divisor/2. If the line is high, it is a false start: return to IDLE with no error.
  - Remaining bits are sampled every divisor cycles after that.
- RX stop sample:
  - 1, parity OK, queue not full: push.
  - 0 (frame error), parity mismatch, or queue full (overrun): discard byte and set sticky error.
- Queues: circular buffers with log2(DEPTH)+1-bit pointers; the MSB distinguishes full from empty; wrap is natural.

## Timing
- Reset values: TX=1, databus=Z, tx_q_full=0, rx_q_empty=1, rx_err=0, divisor=DEFAULT_DIV, DBH[7:5]=0. Queues empty, both FSMs IDLE.
- SREG at reset: 0x80 for DEPTH=8; 0xF0 for DEPTH≥16.
- DBUF write at edge N: SREG/tx_q_full reflect it from edge N+1. If TX is idle, the pop occurs at edge N+1, the start bit drives TX from edge N+2, and the free count returns at N+2.
- Simultaneous DBUF write and TX pop: both occur, count unchanged. The same holds for an RX push with a DBUF read.
- Write to a full queue with a same-cycle pop: accepted.
- One frame lasts 10×div cycles (11×div with parity). A back-to-back frame's start bit follows the stop bit with no idle gap.
- RX push lands at the STOP sample edge + 1.
- rst mid-frame: TX goes high immediately, partial frames are discarded, and queues are flushed.

## Configuration
- SPART_PARITY_EN defined: DBH[7] = parity enable, DBH[6] = odd (0 = even). When enabled, TX appends a parity bit and RX checks it.
- SPART_PARITY_EN undefined: DBH[7:6] read 0, writes to them are ignored, and there is no parity state or logic. Frames are always 8N1.

## Test plan
- Reset, read SREG, DBL, DBH → 0x80, 0xB2, 0x01; tx_q_full=0, rx_q_empty=1, TX=1.
- Write 9 bytes back-to-back to DBUF (DEPTH=8, div=434) → SREG[7:4] goes 8,7,7,6,…; tx_q_full=1 after the 9th. A serial monitor receives all 9 bytes in order, each 4340 cycles.
- Set DBH=0x00, DBL=0x10 (div 16), drive 9 frames on RX → SREG[3:0]=8, rx_err=1 (overrun); 8 DBUF reads return the first 8 bytes; a 9th read returns 0x00 with rx_q_empty=1.
- RX frame 0x55 with stop bit 0 → not queued, DBH[5]=1. Write DBH with bit5=1 → rx_err=0. A 0.3-bit low glitch → no byte queued, no error.
- SPART_PARITY_EN: DBH=0xC1 (odd parity), write 0x03 → TX parity bit 1 and 11-bit frame. RX 0x03 with parity 0 → discarded, rx_err=1.
- Assert rst mid-TX-frame → TX=1 next cycle, SREG=0x80, nothing further transmitted.

Source files
------------

// File: rtl/spart_gen2.sv
// rtl/spart_gen2.sv - memory-mapped byte UART with TX/RX queues, 13-bit baud divisor, sticky error; optional parity via SPART_PARITY_EN

// Byte queue: circular buffer, pointers one bit wider than the index so full and empty differ
module spart_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        wr_en;
   logic        rd_en;

   assign rd_en = pop & ~empty;
   // a full queue still accepts a write when the head leaves in the same cycle
   assign wr_en = push & (~full | rd_en);
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   // storage write
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= wdata;
   end

   // pointer update, wrap is natural modulo 2*DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end
endmodule

module spart_gen2 #(
   parameter int          DEPTH       = 8,
   parameter logic [12:0] DEFAULT_DIV = 13'd434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs_n,
   input  logic       iorw_n,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       tx_q_full,
   output logic       rx_q_empty,
   output logic       rx_err,
   output logic       TX,
   input  logic       RX
);
   localparam int CW = $clog2(DEPTH) + 1;

`ifdef SPART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   function automatic logic [3:0] sat15(input logic [7:0] v);
      return (v > 8'd15) ? 4'hF : v[3:0];
   endfunction

   // bus decode
   logic          wr_cyc, rd_cyc;
   logic [7:0]    rdata;
   logic [12:0]   div;
   logic [12:0]   eff_div;
   logic          err;
   logic          err_set;
   logic [1:0]    dbh_hi;

   // queues
   logic          tx_push, tx_load, tx_empty;
   logic [7:0]    tx_head;
   logic [CW-1:0] tx_count, tx_free;
   logic          rx_push_pend, rx_pop, rx_full, rx_empty, rx_overrun;
   logic [7:0]    rx_head;
   logic [CW-1:0] rx_count;

   // TX engine
   state_t        tx_state, tx_next;
   logic [12:0]   tx_cnt, tx_div;
   logic [2:0]    tx_bitn;
   logic [7:0]    tx_shift;
   logic          tx_tick, tx_bit;

   // RX engine
   state_t        rx_state, rx_next;
   logic          rx_m, rx_s, rx_d, rx_fall;
   logic [12:0]   rx_cnt, rx_div;
   logic [2:0]    rx_bitn;
   logic [7:0]    rx_shift;
   logic          rx_tick, rx_done, rx_bad, rx_good;

`ifdef SPART_PARITY_EN
   logic [1:0]    par_ctl;
   logic          tx_par, tx_par_en;
   logic          rx_par_en, rx_par_odd, rx_par_bad;
   assign dbh_hi = par_ctl;
`else
   assign dbh_hi = 2'b00;
`endif

   assign wr_cyc  = ~iocs_n & ~iorw_n;
   assign rd_cyc  = ~iocs_n &  iorw_n;
   assign tx_push = wr_cyc && (ioaddr == 2'b00);
   assign rx_pop  = rd_cyc && (ioaddr == 2'b00);
   assign eff_div = (div < 13'd16) ? 13'd16 : div;
   assign tx_free = CW'(DEPTH) - tx_count;

   assign databus    = rd_cyc ? rdata : 8'hzz;
   assign rx_q_empty = rx_empty;
   assign rx_err     = err;

   spart_fifo #(.DEPTH(DEPTH)) u_tx_q (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_load), .wdata(databus),
      .rdata(tx_head), .count(tx_count), .full(tx_q_full), .empty(tx_empty)
   );

   spart_fifo #(.DEPTH(DEPTH)) u_rx_q (
      .clk(clk), .rst(rst), .push(rx_push_pend), .pop(rx_pop), .wdata(rx_shift),
      .rdata(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   // register read mux; an empty RX queue reads as zero
   always_comb begin
      rdata = 8'h00;
      case (ioaddr)
         2'b00: rdata = rx_empty ? 8'h00 : rx_head;
         2'b01: rdata = {sat15(8'(tx_free)), sat15(8'(rx_count))};
         2'b10: rdata = div[7:0];
         2'b11: rdata = {dbh_hi, err, div[12:8]};
         default: rdata = 8'h00;
      endcase
   end

   // a completed push would overflow only when no same-cycle read frees a slot
   assign rx_overrun = rx_push_pend & rx_full & ~(rx_pop & ~rx_empty);
   assign err_set    = rx_bad | rx_overrun;

   // divisor, parity control and sticky error; a new error beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= DEFAULT_DIV;
         err <= 1'b0;
`ifdef SPART_PARITY_EN
         par_ctl <= 2'b00;
`endif
      end else begin
         if (wr_cyc && ioaddr == 2'b10) div[7:0] <= databus;
         if (wr_cyc && ioaddr == 2'b11) begin
            div[12:8] <= databus[4:0];
`ifdef SPART_PARITY_EN
            par_ctl <= databus[7:6];
`endif
         end
         if (err_set) err <= 1'b1;
         else if (wr_cyc && ioaddr == 2'b11 && databus[5]) err <= 1'b0;
      end
   end

   assign tx_tick = (tx_cnt == 13'd0);

   // TX state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state <= S_IDLE;
      else     tx_state <= tx_next;
   end

   // TX next state; a waiting byte follows the stop bit with no idle gap
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:  if (!tx_empty) tx_next = S_START;
         S_START: if (tx_tick) tx_next = S_DATA;
         S_DATA:  if (tx_tick && tx_bitn == 3'd7) begin
`ifdef SPART_PARITY_EN
                     tx_next = tx_par_en ? S_PAR : S_STOP;
`else
                     tx_next = S_STOP;
`endif
                  end
`ifdef SPART_PARITY_EN
         S_PAR:   if (tx_tick) tx_next = S_STOP;
`endif
         S_STOP:  if (tx_tick) tx_next = tx_empty ? S_IDLE : S_START;
         default: tx_next = S_IDLE;
      endcase
   end

   // TX outputs: line level and queue pop at each frame start
   always_comb begin
      tx_bit  = 1'b1;
      tx_load = 1'b0;
      case (tx_state)
         S_IDLE:  tx_load = !tx_empty;
         S_START: tx_bit  = 1'b0;
         S_DATA:  tx_bit  = tx_shift[0];
`ifdef SPART_PARITY_EN
         S_PAR:   tx_bit  = tx_par;
`endif
         S_STOP:  tx_load = tx_tick && !tx_empty;
         default: tx_bit  = 1'b1;
      endcase
   end

   // TX datapath: divisor and parity settings are frozen for the whole frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_cnt   <= '0;
         tx_div   <= 13'd16;
         tx_bitn  <= '0;
         tx_shift <= '0;
`ifdef SPART_PARITY_EN
         tx_par    <= 1'b0;
         tx_par_en <= 1'b0;
`endif
      end else if (tx_load) begin
         tx_shift <= tx_head;
         tx_div   <= eff_div;
         tx_cnt   <= eff_div - 13'd1;
         tx_bitn  <= '0;
`ifdef SPART_PARITY_EN
         tx_par    <= (^tx_head) ^ par_ctl[0];
         tx_par_en <= par_ctl[1];
`endif
      end else if (tx_tick) begin
         tx_cnt <= tx_div - 13'd1;
         if (tx_state == S_DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bitn  <= tx_bitn + 3'd1;
         end
      end else begin
         tx_cnt <= tx_cnt - 13'd1;
      end
   end

   // TX line register, forced idle-high by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) TX <= 1'b1;
      else     TX <= tx_bit;
   end

   // RX synchroniser plus one delay stage for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= RX;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign rx_fall = rx_d & ~rx_s;
   assign rx_tick = (rx_cnt == 13'd0);

   // RX state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_state <= S_IDLE;
      else     rx_state <= rx_next;
   end

   // RX next state; a high line at mid start bit is a glitch, not a frame
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_fall) rx_next = S_START;
         S_START: if (rx_tick) rx_next = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (rx_tick && rx_bitn == 3'd7) begin
`ifdef SPART_PARITY_EN
                     rx_next = rx_par_en ? S_PAR : S_STOP;
`else
                     rx_next = S_STOP;
`endif
                  end
`ifdef SPART_PARITY_EN
         S_PAR:   if (rx_tick) rx_next = S_STOP;
`endif
         S_STOP:  if (rx_tick) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end

   // RX outputs: frame verdict at the stop sample
   always_comb begin
      rx_done = (rx_state == S_STOP) && rx_tick;
`ifdef SPART_PARITY_EN
      rx_bad  = rx_done && (!rx_s || rx_par_bad);
`else
      rx_bad  = rx_done && !rx_s;
`endif
      rx_good = rx_done && !rx_bad;
   end

   // RX datapath: half-period to mid start bit, then one full period per bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_cnt       <= '0;
         rx_div       <= 13'd16;
         rx_bitn      <= '0;
         rx_shift     <= '0;
         rx_push_pend <= 1'b0;
`ifdef SPART_PARITY_EN
         rx_par_en  <= 1'b0;
         rx_par_odd <= 1'b0;
         rx_par_bad <= 1'b0;
`endif
      end else begin
         rx_push_pend <= rx_good;
         if (rx_state == S_IDLE) begin
            if (rx_fall) begin
               rx_div  <= eff_div;
               rx_cnt  <= (eff_div >> 1) - 13'd1;
               rx_bitn <= '0;
`ifdef SPART_PARITY_EN
               rx_par_en  <= par_ctl[1];
               rx_par_odd <= par_ctl[0];
               rx_par_bad <= 1'b0;
`endif
            end
         end else if (rx_tick) begin
            rx_cnt <= rx_div - 13'd1;
            if (rx_state == S_DATA) begin
               rx_shift <= {rx_s, rx_shift[7:1]};
               rx_bitn  <= rx_bitn + 3'd1;
            end
`ifdef SPART_PARITY_EN
            if (rx_state == S_PAR) rx_par_bad <= rx_s != ((^rx_shift) ^ rx_par_odd);
`endif
         end else begin
            rx_cnt <= rx_cnt - 13'd1;
         end
      end
   end
endmodule

// File: tb/tb_spart_gen2.sv
// tb/tb_spart_gen2.sv - directed self-checking bench for spart_gen2

module tb_spart_gen2;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iocs_n = 1'b1;
   logic       iorw_n = 1'b1;
   logic [1:0] ioaddr = 2'b00;
   wire  [7:0] databus;
   logic [7:0] tb_dout = 8'h00;
   logic       tb_drive = 1'b0;
   logic       tx_q_full, rx_q_empty, rx_err, TX;
   logic       RX = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int bit_cyc = 16;
   int mon_div = 434;
   bit mon_par_en = 1'b0;
   logic [7:0] mon_q[$];
   logic       mon_par[$];
   logic       mon_stop[$];
   int         mon_t[$];

   assign databus = tb_drive ? tb_dout : 8'hzz;

   spart_gen2 dut (
      .clk(clk), .rst(rst), .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr),
      .databus(databus), .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty),
      .rx_err(rx_err), .TX(TX), .RX(RX)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs_n = 1'b0; iorw_n = 1'b0; ioaddr = a; tb_dout = d; tb_drive = 1'b1;
      @(posedge clk); #1;
      iocs_n = 1'b1; iorw_n = 1'b1; tb_drive = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      iocs_n = 1'b0; iorw_n = 1'b1; ioaddr = a;
      #1 d = databus;
      @(posedge clk); #1;
      iocs_n = 1'b1;
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
      logic [7:0] d;
      bus_read(a, d);
      check(tag, {24'h0, d}, {24'h0, exp});
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input logic use_par, input logic par);
      @(negedge clk);
      RX = 1'b0;
      repeat (bit_cyc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (bit_cyc) @(negedge clk);
      end
      if (use_par) begin
         RX = par;
         repeat (bit_cyc) @(negedge clk);
      end
      RX = stop;
      repeat (bit_cyc) @(negedge clk);
      RX = 1'b1;
   endtask

   task automatic mon_clear();
      mon_q.delete(); mon_par.delete(); mon_stop.delete(); mon_t.delete();
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (mon_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      check("tx_frames_seen", mon_q.size(), n);
   endtask

   // serial monitor: mid-bit sampling of TX
   initial begin
      logic [7:0] b;
      logic       p, s;
      int         t0;
      forever begin
         @(negedge TX);
         t0 = cyc;
         repeat (mon_div / 2) @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (mon_div) @(posedge clk);
            b[i] = TX;
         end
         p = 1'b0;
         if (mon_par_en) begin
            repeat (mon_div) @(posedge clk);
            p = TX;
         end
         repeat (mon_div) @(posedge clk);
         s = TX;
         mon_q.push_back(b); mon_par.push_back(p); mon_stop.push_back(s); mon_t.push_back(t0);
      end
   end

   initial begin
      logic [7:0] tx_bytes [9] = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h7E};
      logic [7:0] rx_bytes [9] = '{8'h11, 8'h22, 8'h96, 8'h69, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'hE7};
      int lows;
      int k;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      check("rst_tx", TX, 1);
      check("rst_full", tx_q_full, 0);
      check("rst_empty", rx_q_empty, 1);
      check("rst_err", rx_err, 0);
      tb_dout = 8'h3C; tb_drive = 1'b1; #1;
      check("bus_released", databus, 8'h3C);
      tb_drive = 1'b0;
      read_check("rst_sreg", 2'b01, 8'h80);
      read_check("rst_dbl", 2'b10, 8'hB2);
      read_check("rst_dbh", 2'b11, 8'h01);
      mon_clear();

      // nine back-to-back TX writes at div 434
      for (int i = 0; i < 9; i++) begin
         bus_write(2'b00, tx_bytes[i]);
         check($sformatf("tx_full_after_w%0d", i), tx_q_full, (i == 8) ? 1 : 0);
      end
      read_check("sreg_tx_full", 2'b01, 8'h00);
      wait_frames(9, 9 * 4340 + 2000);
      for (int i = 0; i < 9 && i < mon_q.size(); i++) begin
         check($sformatf("tx_byte%0d", i), mon_q[i], tx_bytes[i]);
         check($sformatf("tx_stop%0d", i), mon_stop[i], 1);
         if (i > 0) check($sformatf("tx_spacing%0d", i), mon_t[i] - mon_t[i-1], 4340);
      end
      repeat (300) @(posedge clk);
      read_check("sreg_tx_drained", 2'b01, 8'h80);

      // RX overrun at divisor 16
      bus_write(2'b11, 8'h00);
      bus_write(2'b10, 8'h10);
      read_check("dbl_16", 2'b10, 8'h10);
      read_check("dbh_00", 2'b11, 8'h00);
      mon_div = 16; bit_cyc = 16;
      for (int i = 0; i < 9; i++) send_rx(rx_bytes[i], 1'b1, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      read_check("sreg_rx8", 2'b01, 8'h88);
      check("overrun_err", rx_err, 1);
      check("rx_not_empty", rx_q_empty, 0);
      for (int i = 0; i < 8; i++) read_check($sformatf("rx_byte%0d", i), 2'b00, rx_bytes[i]);
      read_check("rx_read_empty", 2'b00, 8'h00);
      check("rx_empty_after", rx_q_empty, 1);
      bus_write(2'b11, 8'h20);
      check("err_cleared", rx_err, 0);

      // frame error, then glitch, then a good frame
      send_rx(8'h55, 1'b0, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      check("ferr_not_queued", rx_q_empty, 1);
      read_check("ferr_dbh", 2'b11, 8'h20);
      bus_write(2'b11, 8'h20);
      check("ferr_cleared", rx_err, 0);
      @(negedge clk); RX = 1'b0;
      repeat (5) @(negedge clk);
      RX = 1'b1;
      repeat (40) @(posedge clk);
      check("glitch_empty", rx_q_empty, 1);
      check("glitch_no_err", rx_err, 0);
      send_rx(8'hA5, 1'b1, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      read_check("rx_after_glitch", 2'b00, 8'hA5);

`ifdef SPART_PARITY_EN
      // odd parity on both directions
      bus_write(2'b11, 8'hC0);
      read_check("dbh_parity", 2'b11, 8'hC0);
      mon_par_en = 1'b1;
      mon_clear();
      bus_write(2'b00, 8'h03);
      bus_write(2'b00, 8'h01);
      wait_frames(2, 800);
      if (mon_q.size() >= 2) begin
         check("par_byte0", mon_q[0], 8'h03);
         check("par_bit0", mon_par[0], 1);
         check("par_byte1", mon_q[1], 8'h01);
         check("par_bit1", mon_par[1], 0);
         check("par_stop1", mon_stop[1], 1);
         check("par_spacing", mon_t[1] - mon_t[0], 176);
      end
      send_rx(8'h03, 1'b1, 1'b1, 1'b0);
      repeat (30) @(posedge clk);
      check("par_bad_empty", rx_q_empty, 1);
      check("par_bad_err", rx_err, 1);
      bus_write(2'b11, 8'hE0);
      send_rx(8'h03, 1'b1, 1'b1, 1'b1);
      repeat (30) @(posedge clk);
      check("par_good_err", rx_err, 0);
      read_check("par_good_byte", 2'b00, 8'h03);
      bus_write(2'b11, 8'h00);
      mon_par_en = 1'b0;
      repeat (200) @(posedge clk);
`else
      // DBH[7:6] read as zero in the 8N1 build
      bus_write(2'b11, 8'hC0);
      read_check("dbh_no_parity", 2'b11, 8'h00);
`endif

      // free count timing, then reset mid-frame
      bus_write(2'b00, 8'h5A);
      read_check("sreg_after_write", 2'b01, 8'h70);
      read_check("sreg_after_pop", 2'b01, 8'h80);
      bus_write(2'b00, 8'h12);
      bus_write(2'b00, 8'h34);
      k = 0;
      while (TX !== 1'b0 && k < 40) begin
         @(posedge clk);
         k++;
      end
      check("tx_frame_started", TX, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      check("rst_async_tx", TX, 1);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      read_check("post_rst_sreg", 2'b01, 8'h80);
      read_check("post_rst_dbl", 2'b10, 8'hB2);
      check("post_rst_full", tx_q_full, 0);
      lows = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (TX !== 1'b1) lows++;
      end
      check("post_rst_tx_quiet", lows, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
